// File: rtl/cycle_pkg.sv
// Shared widths, state encoding and saturating period-code arithmetic
// for the nfork speed-profile sequencer.
package cycle_pkg;

    localparam int CODE_W = 8;
    localparam int HOLD_W = 16;
    localparam int WDOG_W = 24;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        HOLD      = 2'd2,
        RAMP_DOWN = 2'd3
    } fork_prof_state_t;

    // Faster direction: code falls by step, never below floor.
    function automatic logic [CODE_W-1:0] sat_dec(
        input logic [CODE_W-1:0] code,
        input logic [CODE_W-1:0] step,
        input logic [CODE_W-1:0] floor
    );
        logic [CODE_W:0] diff;
        diff = {1'b0, code} - {1'b0, step};
        if (diff[CODE_W] || (diff[CODE_W-1:0] < floor)) begin
            return floor;
        end
        return diff[CODE_W-1:0];
    endfunction

    // Slower direction: one extra bit so the sum cannot wrap past the ceiling.
    function automatic logic [CODE_W-1:0] sat_inc(
        input logic [CODE_W-1:0] code,
        input logic [CODE_W-1:0] step,
        input logic [CODE_W-1:0] ceil
    );
        logic [CODE_W:0] sum;
        sum = {1'b0, code} + {1'b0, step};
        if (sum > {1'b0, ceil}) begin
            return ceil;
        end
        return sum[CODE_W-1:0];
    endfunction

endpackage

// File: rtl/fork_edge_watchdog.sv
// Detects falling edges of the generator's nfork pulse and flags a stall when
// no edge has been seen for STALL_CYCLES cycles while armed.
module fork_edge_watchdog
    import cycle_pkg::*;
#(
    parameter logic [WDOG_W-1:0] STALL_CYCLES = 24'd1000000
) (
    input  logic clk,
    input  logic nReset,
    input  logic nfork_in,
    input  logic arm,
    input  logic clear,
    output logic fork_edge,
    output logic stall
);

    logic              nfork_prev_q;
    logic [WDOG_W-1:0] wdog_q;
    logic [WDOG_W-1:0] wdog_d;

    assign fork_edge = nfork_prev_q & ~nfork_in;

    always_comb begin
        wdog_d = wdog_q + {{(WDOG_W-1){1'b0}}, 1'b1};
        if (clear || !arm || fork_edge) begin
            wdog_d = '0;
        end
    end

    // Fires in the cycle the counter would reach the limit, so the owner reacts on that edge.
    assign stall = arm && (wdog_d == STALL_CYCLES);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            nfork_prev_q <= 1'b1;
            wdog_q       <= '0;
        end else begin
            nfork_prev_q <= nfork_in;
            wdog_q       <= wdog_d;
        end
    end

endmodule

// File: rtl/fork_profile_sequencer.sv
// Steps the nfork generator period code through ramp-up, hold and ramp-down,
// pacing each step on nfork falling edges, with abort and stall watchdog.
module fork_profile_sequencer
    import cycle_pkg::*;
#(
    parameter logic [CODE_W-1:0] MAX_CODE     = 8'd255,
    parameter logic [CODE_W-1:0] STEP         = 8'd8,
    parameter logic [WDOG_W-1:0] STALL_CYCLES = 24'd1000000
) (
    input  logic              core_CLK,
    input  logic              core_nReset,
    input  logic              start,
    input  logic              abort,
    input  logic [CODE_W-1:0] target,
    input  logic [CODE_W-1:0] step_pulses,
    input  logic [HOLD_W-1:0] hold_pulses,
    input  logic              nfork_in,
    output logic [CODE_W-1:0] speed_code,
    output logic              busy,
    output logic              done,
    output logic              stalled
);

    fork_prof_state_t  state_q;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] target_q;
    logic [CODE_W-1:0] step_q;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              stalled_q;

    logic              fork_edge;
    logic              stall;
    logic              start_ok;
    logic              step_hit;
    logic              hold_hit;
    logic [HOLD_W-1:0] cnt_inc;
    logic [CODE_W-1:0] code_dn_d;
    logic [CODE_W-1:0] code_up_d;

    fork_edge_watchdog #(
        .STALL_CYCLES(STALL_CYCLES)
    ) u_wdog (
        .clk      (core_CLK),
        .nReset   (core_nReset),
        .nfork_in (nfork_in),
        .arm      (busy_q),
        .clear    (start_ok),
        .fork_edge(fork_edge),
        .stall    (stall)
    );

    assign start_ok  = (state_q == IDLE) && start && !abort && (target != '0);
    assign cnt_inc   = cnt_q + {{(HOLD_W-1){1'b0}}, 1'b1};
    assign step_hit  = fork_edge && (cnt_inc == {{(HOLD_W-CODE_W){1'b0}}, step_q});
    assign hold_hit  = fork_edge && (cnt_inc == hold_q);
    assign code_dn_d = sat_dec(code_q, STEP, target_q);
    assign code_up_d = sat_inc(code_q, STEP, MAX_CODE);

    always_ff @(posedge core_CLK or negedge core_nReset) begin
        if (!core_nReset) begin
            state_q   <= IDLE;
            code_q    <= '0;
            target_q  <= '0;
            step_q    <= '0;
            hold_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        target_q  <= target;
                        step_q    <= (step_pulses == '0) ? 8'd1 : step_pulses;
                        hold_q    <= hold_pulses;
                        cnt_q     <= '0;
                        stalled_q <= 1'b0;
                        busy_q    <= 1'b1;
                        if (target >= MAX_CODE) begin
                            state_q <= HOLD;
                            code_q  <= target;
                        end else begin
                            state_q <= RAMP_UP;
                            code_q  <= MAX_CODE;
                        end
                    end
                end
                RAMP_UP: begin
                    if (code_q == target_q) begin
                        state_q <= HOLD;
                        cnt_q   <= '0;
                    end else if (step_hit) begin
                        cnt_q  <= '0;
                        code_q <= code_dn_d;
                    end else if (fork_edge) begin
                        cnt_q <= cnt_inc;
                    end
                end
                HOLD: begin
                    if ((hold_q == '0) || hold_hit) begin
                        state_q <= RAMP_DOWN;
                        cnt_q   <= '0;
                    end else if (fork_edge) begin
                        cnt_q <= cnt_inc;
                    end
                end
                RAMP_DOWN: begin
                    if (code_q == MAX_CODE) begin
                        state_q <= IDLE;
                        code_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (step_hit) begin
                        cnt_q  <= '0;
                        code_q <= code_up_d;
                    end else if (fork_edge) begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Abort and stall override whatever the active state decided this cycle.
            if ((state_q != IDLE) && (abort || stall)) begin
                state_q <= IDLE;
                code_q  <= '0;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
                if (stall) begin
                    stalled_q <= 1'b1;
                end
            end
        end
    end

    assign speed_code = code_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign stalled    = stalled_q;

endmodule
